// File: rtl/reg_readout_pkg.sv
// Shared constants and FSM state encoding for the register readout block.
package reg_readout_pkg;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/reg_readout_prio_enc16.sv
// Combinational lowest-set-bit encoder: 16-bit vector in, index and any-bit-set out.
module prio_enc16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        any_o
);
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end
endmodule

// File: rtl/reg_readout.sv
// Scans a latched bit mask and emits the selected registers one word at a time
// over a valid/ready handshake, lowest index first, then pulses done.
module reg_readout #(
    parameter int NUM_REGS = reg_readout_pkg::NUM_REGS,
    parameter int DATA_W   = reg_readout_pkg::DATA_W
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start,
    input  logic [NUM_REGS-1:0]        rd_mask,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0]          out_data,
    output logic [3:0]                 out_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done
);
    import reg_readout_pkg::*;

    state_e              state_q;
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [DATA_W-1:0]   out_data_q;
    logic [3:0]          out_idx_q;
    logic                out_valid_q;
    logic                done_q;

    logic [15:0]         enc_in;
    logic [3:0]          enc_idx;
    logic                enc_any;
    logic [DATA_W-1:0]   words [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_words
            assign words[gi] = reg_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        enc_in                 = '0;
        enc_in[NUM_REGS-1:0]   = pending_q;
    end

    prio_enc16 u_prio_enc (
        .vec_i (enc_in),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

    always_comb begin
        pending_d          = pending_q;
        pending_d[enc_idx] = 1'b0;
    end

    // start outside IDLE falls through every branch below and is dropped.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pending_q <= rd_mask;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (enc_any) begin
                        out_data_q  <= words[enc_idx];
                        out_idx_q   <= enc_idx;
                        out_valid_q <= 1'b1;
                        pending_q   <= pending_d;
                        state_q     <= ST_HOLD;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_reg_readout.sv
// Randomised self-checking bench for reg_readout against a mask/queue reference model.
module tb_reg_readout;
    localparam int NR = 16;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [NR-1:0]     rd_mask;
    logic [NR*DW-1:0]  reg_data;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_readout #(.NUM_REGS(NR), .DATA_W(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .rd_mask   (rd_mask),
        .reg_data  (reg_data),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word_of(input int i);
        return reg_data[i*DW +: DW];
    endfunction

    task automatic randomize_regs();
        for (int i = 0; i < NR; i++) reg_data[i*DW +: DW] = $urandom();
    endtask

    // Reference: expected words are the set bits of the mask in ascending order,
    // each carrying the register value; with ready always high each word costs 2 cycles.
    task automatic do_readout(input logic [NR-1:0] mask, input int ready_pct,
                              input int exp_done_cyc, input int repulse_at,
                              input logic [NR-1:0] repulse_mask, input string name);
        int exp_q[$];
        int got;
        int cyc;
        bit finished;
        for (int i = 0; i < NR; i++) if (mask[i]) exp_q.push_back(i);
        start = 1'b1; rd_mask = mask;
        step();
        start = 1'b0; rd_mask = NR'($urandom());
        got = 0; cyc = 0; finished = 1'b0;
        while (!finished) begin
            start = (cyc == repulse_at);
            if (start) rd_mask = repulse_mask;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid) begin
                n_checks++;
                if (got >= exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s extra_word: got idx=%0d data=%08h, required no word", name, out_idx, out_data);
                end else if (out_idx !== 4'(exp_q[got]) || out_data !== word_of(exp_q[got])) begin
                    n_fail++;
                    $display("FAIL %s word%0d: got idx=%0d data=%08h, required idx=%0d data=%08h",
                             name, got, out_idx, out_data, exp_q[got], word_of(exp_q[got]));
                end
                if (out_ready) got++;
            end
            if (done) begin
                n_checks++;
                if (got != exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s word_count: got %0d, required %0d", name, got, exp_q.size());
                end
                if (exp_done_cyc >= 0) begin
                    n_checks++;
                    if (cyc != exp_done_cyc) begin
                        n_fail++;
                        $display("FAIL %s done_cycle: got %0d, required %0d", name, cyc, exp_done_cyc);
                    end
                end
                finished = 1'b1;
            end
            if (!finished) begin
                if (cyc >= 200) begin
                    n_checks++; n_fail++;
                    $display("FAIL %s timeout: no done after %0d cycles, required done", name, cyc);
                    finished = 1'b1;
                end else begin
                    step();
                    cyc++;
                end
            end
        end
        start = 1'b0; out_ready = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: got busy=%b done=%b, required 0 0", name, busy, done);
        end
        $display("readout %s mask=%04h words=%0d done_cyc=%0d", name, mask, got, cyc);
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b1; rd_mask = '1; out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%08h i=%0d busy=%b done=%b, required all 0",
                     out_valid, out_data, out_idx, busy, done);
        end
        clr = 1'b1; start = 1'b0; out_ready = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b, required 0", busy);
        end
        $display("reset checked");
    endtask

    task automatic test_two_words();
        randomize_regs();
        reg_data[0*DW +: DW] = 32'hAAAA0000;
        reg_data[2*DW +: DW] = 32'h12345678;
        do_readout(16'h0005, 100, 5, -1, '0, "two_words");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w0;
        int waited;
        randomize_regs();
        w0 = word_of(0);
        out_ready = 1'b0; start = 1'b1; rd_mask = 16'h8001;
        step();
        start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin step(); waited++; end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== w0) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: got v=%b i=%0d d=%08h, required v=1 i=0 d=%08h",
                         c, out_valid, out_idx, out_data, w0);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: got v=%b busy=%b, required v=0 busy=1", out_valid, busy);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd15 || out_data !== word_of(15)) begin
            n_fail++;
            $display("FAIL bp_word15: got v=%b i=%0d d=%08h, required v=1 i=15 d=%08h",
                     out_valid, out_idx, out_data, word_of(15));
        end
        step();
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got done=%b, required 1", done);
        end
        out_ready = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        $display("readout backpressure mask=8001 held=6");
    endtask

    task automatic test_hold_stable();
        logic [DW-1:0] old;
        randomize_regs();
        old = word_of(0);
        out_ready = 1'b0; start = 1'b1; rd_mask = 16'h0001;
        step();
        start = 1'b0;
        step();
        reg_data[0*DW +: DW] = ~old;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== old) begin
                n_fail++;
                $display("FAIL hold_stable c%0d: got v=%b d=%08h, required v=1 d=%08h", c, out_valid, out_data, old);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_done: got done=%b, required 1", done);
        end
        step();
        $display("readout hold_stable mask=0001");
    endtask

    task automatic test_reset_mid();
        randomize_regs();
        out_ready = 1'b0; start = 1'b1; rd_mask = 16'h0006;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_first: got v=%b i=%0d, required v=1 i=1", out_valid, out_idx);
        end
        clr = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%08h i=%0d busy=%b done=%b, required all 0",
                     out_valid, out_data, out_idx, busy, done);
        end
        clr = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_silent c%0d: got done=%b v=%b, required 0 0", c, done, out_valid);
            end
        end
        do_readout(16'h0004, 100, 3, -1, '0, "after_reset");
    endtask

    task automatic test_full();
        for (int i = 0; i < NR; i++) reg_data[i*DW +: DW] = 32'(i) * 32'h01010101;
        do_readout(16'hFFFF, 100, 33, -1, '0, "full");
    endtask

    task automatic test_empty();
        randomize_regs();
        do_readout(16'h0000, 100, 1, -1, '0, "empty");
    endtask

    task automatic test_restart_ignored();
        randomize_regs();
        do_readout(16'h0009, 100, 5, 2, 16'h0002, "restart_ignored");
        randomize_regs();
        do_readout(16'h0009, 60, -1, 3, 16'h0002, "restart_ignored_bp");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 20; n++) begin
            logic [NR-1:0] m;
            int pct;
            m = NR'($urandom());
            pct = (n % 4 == 0) ? 100 : int'($urandom_range(30, 99));
            randomize_regs();
            do_readout(m, pct, (pct == 100) ? 2 * $countones(m) + 1 : -1, -1, '0, "random");
        end
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; rd_mask = '0; out_ready = 1'b0; reg_data = '0;
        test_reset();
        test_two_words();
        test_backpressure();
        test_empty();
        test_full();
        test_restart_ignored();
        test_hold_stable();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
